// File: rtl/vector_alu_pkg.sv
// Shared types and helpers for the packed-lane vector ALU.
package vector_alu_pkg;

  typedef enum logic [1:0] {
    OP_ADD = 2'b00,
    OP_SUB = 2'b01,
    OP_MUL = 2'b10,
    OP_DIV = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_DIV  = 2'b01,
    S_HOLD = 2'b10
  } state_e;

  // Low bit index of a lane inside a packed word.
  function automatic int lane_lo(input int lane, input int lane_w);
    return lane * lane_w;
  endfunction

endpackage

// File: rtl/vector_div_lane.sv
// One lane of the iterative unsigned divider: restoring step per enable.
module vector_div_lane
  import vector_alu_pkg::*;
#(
  parameter int LANE_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              en,
  input  logic [LANE_W-1:0] a,
  input  logic [LANE_W-1:0] b,
  output logic [LANE_W-1:0] quo,
  output logic              dz
);

  logic [LANE_W-1:0] rem_q, rem_d;
  logic [LANE_W-1:0] quo_q, quo_d;
  logic [LANE_W-1:0] dvs_q, dvs_d;
  logic              dz_q, dz_d;
  logic [LANE_W:0]   rem_sh, trial;

  // A zero divisor never produces a negative trial, so the quotient fills with ones.
  always_comb begin
    rem_d  = rem_q;
    quo_d  = quo_q;
    dvs_d  = dvs_q;
    dz_d   = dz_q;
    rem_sh = {rem_q, quo_q[LANE_W-1]};
    trial  = rem_sh - {1'b0, dvs_q};
    if (start) begin
      rem_d = '0;
      quo_d = a;
      dvs_d = b;
      dz_d  = (b == '0);
    end else if (en) begin
      if (!trial[LANE_W]) begin
        rem_d = trial[LANE_W-1:0];
        quo_d = {quo_q[LANE_W-2:0], 1'b1};
      end else begin
        rem_d = rem_sh[LANE_W-1:0];
        quo_d = {quo_q[LANE_W-2:0], 1'b0};
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rem_q <= '0;
      quo_q <= '0;
      dvs_q <= '0;
      dz_q  <= 1'b0;
    end else begin
      rem_q <= rem_d;
      quo_q <= quo_d;
      dvs_q <= dvs_d;
      dz_q  <= dz_d;
    end
  end

  assign quo = quo_q;
  assign dz  = dz_q;

endmodule

// File: rtl/vector_alu_pipe.sv
// Handshaked SIMD ALU: single-cycle add/sub/mul, LANE_W-step iterative divide.
module vector_alu_pipe
  import vector_alu_pkg::*;
#(
  parameter int LANES  = 4,
  parameter int LANE_W = 8
) (
  input  logic                    CLK,
  input  logic                    RST_N,
  input  logic                    IN_VALID,
  output logic                    IN_READY,
  input  logic [LANES*LANE_W-1:0] IN0,
  input  logic [LANES*LANE_W-1:0] IN1,
  input  logic [1:0]              OP,
  input  logic                    SAT,
  output logic                    OUT_VALID,
  input  logic                    OUT_READY,
  output logic [LANES*LANE_W-1:0] OUT,
  output logic [LANES-1:0]        OVF,
  output logic [LANES-1:0]        DZ
);

  localparam int CNT_W = $clog2(LANE_W + 1);

  state_e                        state_q, state_d;
  logic [CNT_W-1:0]              cnt_q, cnt_d;
  logic [LANES-1:0][LANE_W-1:0]  res_q, res_d;
  logic [LANES-1:0]              ovf_q, ovf_d;
  logic                          div_sel_q, div_sel_d;

  logic [LANES-1:0][LANE_W-1:0]  in0_v, in1_v, alu_res, quo_v;
  logic [LANES-1:0]              alu_ovf, dz_v;
  logic [LANE_W:0]               sum, diff;
  logic [2*LANE_W-1:0]           prod;
  op_e                           op;
  logic                          acc, div_start, div_en;

  assign in0_v = IN0;
  assign in1_v = IN1;
  assign op    = op_e'(OP);

  always_comb begin
    alu_res = '0;
    alu_ovf = '0;
    sum     = '0;
    diff    = '0;
    prod    = '0;
    for (int i = 0; i < LANES; i++) begin
      sum  = {1'b0, in0_v[i]} + {1'b0, in1_v[i]};
      diff = {1'b0, in0_v[i]} - {1'b0, in1_v[i]};
      prod = {{LANE_W{1'b0}}, in0_v[i]} * {{LANE_W{1'b0}}, in1_v[i]};
      unique case (op)
        OP_ADD: begin
          alu_ovf[i] = sum[LANE_W];
          alu_res[i] = (SAT && sum[LANE_W]) ? '1 : sum[LANE_W-1:0];
        end
        OP_SUB: begin
          alu_ovf[i] = diff[LANE_W];
          alu_res[i] = (SAT && diff[LANE_W]) ? '0 : diff[LANE_W-1:0];
        end
        OP_MUL: begin
          alu_ovf[i] = |prod[2*LANE_W-1:LANE_W];
          alu_res[i] = (SAT && alu_ovf[i]) ? '1 : prod[LANE_W-1:0];
        end
        default: ;
      endcase
    end
  end

  assign IN_READY  = (state_q == S_IDLE) || ((state_q == S_HOLD) && OUT_READY);
  assign acc       = IN_VALID && IN_READY;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    res_d     = res_q;
    ovf_d     = ovf_q;
    div_sel_d = div_sel_q;
    div_start = 1'b0;
    div_en    = 1'b0;
    unique case (state_q)
      S_IDLE, S_HOLD: begin
        if (acc) begin
          if (op == OP_DIV) begin
            state_d   = S_DIV;
            cnt_d     = '0;
            ovf_d     = '0;
            div_sel_d = 1'b1;
            div_start = 1'b1;
          end else begin
            state_d   = S_HOLD;
            res_d     = alu_res;
            ovf_d     = alu_ovf;
            div_sel_d = 1'b0;
          end
        end else if ((state_q == S_HOLD) && OUT_READY) begin
          state_d = S_IDLE;
        end
      end
      S_DIV: begin
        div_en = 1'b1;
        cnt_d  = cnt_q + 1'b1;
        if (cnt_q == CNT_W'(LANE_W - 1)) state_d = S_HOLD;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      res_q     <= '0;
      ovf_q     <= '0;
      div_sel_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      res_q     <= res_d;
      ovf_q     <= ovf_d;
      div_sel_q <= div_sel_d;
    end
  end

  for (genvar g = 0; g < LANES; g++) begin : g_div
    vector_div_lane #(.LANE_W(LANE_W)) u_lane (
      .clk   (CLK),
      .rst_n (RST_N),
      .start (div_start),
      .en    (div_en),
      .a     (IN0[lane_lo(g, LANE_W) +: LANE_W]),
      .b     (IN1[lane_lo(g, LANE_W) +: LANE_W]),
      .quo   (quo_v[g]),
      .dz    (dz_v[g])
    );
  end

  // The divider's own registers double as the result store for DIV.
  assign OUT_VALID = (state_q == S_HOLD);
  assign OUT       = div_sel_q ? quo_v : res_q;
  assign OVF       = ovf_q;
  assign DZ        = div_sel_q ? dz_v : '0;

endmodule
